alu_scheduler: RTL and testbench

Controller that shares one serial-load `alu` between two requesters. It accepts whole-operation requests (op, A, B) with round-robin arbitration and drives the ALU's `BEGIN`/`op_code`/`inbus` load sequence. It waits for `END`, captures one or two result bytes from `outbus` and returns them with the requester's ID. A watchdog aborts and resets the ALU if `END` never arrives. It sits between the ALU and the two client blocks; the ALU is instantiated outside it.

---
 rtl/alu_scheduler.sv | 146 ++++++++++++++
 tb/tb_alu_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// Shares one serial-load ALU between two requesters: round-robin accept, drive the
// BEGIN/op_code/inbus load sequence, capture one or two result bytes, watchdog abort.
module alu_scheduler #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end,
    output logic        alu_reset,
    output logic [2:0]  dbg_state
);
    localparam int WD_W = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_LOAD_A  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPT_HI = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;
    localparam logic [2:0] S_RESPOND = 3'd6;

    logic [2:0]      state;
    logic            last_grant;
    logic [7:0]      a_q;
    logic [7:0]      b_q;
    logic [WD_W-1:0] wd;
    logic            grant0;
    logic            grant1;

    // Handshake: a request moves on the rising edge where valid and ready are both
    // high; a response is consumed on the rising edge where rsp_valid and rsp_ready
    // are both high. rsp_valid and its payload stay put until that edge.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && !grant0;
        req0_ready = (state == S_IDLE) && grant0;
        req1_ready = (state == S_IDLE) && grant1;
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            wd          <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            alu_begin   <= 1'b0;
            alu_op_code <= '0;
            alu_inbus   <= '0;
            alu_reset   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        // last_grant records who won, so the other side wins the next tie
                        last_grant  <= grant1;
                        rsp_id      <= grant1;
                        alu_op_code <= grant1 ? req1_op : req0_op;
                        a_q         <= grant1 ? req1_a : req0_a;
                        b_q         <= grant1 ? req1_b : req0_b;
                        alu_begin   <= 1'b1;
                        alu_inbus   <= '0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_inbus <= a_q;
                    state     <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    alu_begin <= 1'b0;
                    alu_inbus <= b_q;
                    wd        <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_end) begin
                        rsp_data <= {8'h00, alu_outbus};
                        if (alu_op_code[1]) begin
                            state <= S_CAPT_HI;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= S_RESPOND;
                        end
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        alu_reset <= 1'b1;
                        wd        <= '0;
                        state     <= S_RECOVER;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_CAPT_HI: begin
                    // the ALU puts the high byte on outbus the cycle after END
                    rsp_data[15:8] <= alu_outbus;
                    rsp_valid      <= 1'b1;
                    state          <= S_RESPOND;
                end
                S_RECOVER: begin
                    if (wd == '0) begin
                        wd <= WD_W'(1);
                    end else begin
                        alu_reset <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_scheduler.sv
// Randomized scoreboard bench for alu_scheduler with a reactive serial-load ALU model
// and a reference model of arbitration, results and response timing.
module tb_alu_scheduler;
    localparam int TMO = 8;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_data;
    logic        alu_begin, alu_end, alu_reset;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus, alu_outbus;
    logic [2:0]  dbg_state;

    alu_scheduler #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
        .alu_outbus(alu_outbus), .alu_end(alu_end), .alu_reset(alu_reset),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         dly;
        bit         hang;
    } req_t;

    req_t        rq0[$];
    req_t        rq1[$];
    logic [49:0] exp_q[$];   // {due cycle[31:0], id, err, data[15:0]}
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          model_last = 1'b1;
    bit          acc0 = 1'b0, acc1 = 1'b0;
    int          cur_dly = 0;
    bit          cur_hang = 1'b0;
    int          rdy_mode = 1;   // 0 hold off, 1 always ready, 2 random

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [7:0] a,
                                               input logic [7:0] b);
        case (op)
            2'd0:    return {8'h00, 8'(a + b)};
            2'd1:    return {8'h00, 8'(a - b)};
            2'd2:    return 16'(a * b);
            default: return (b == 0) ? {a, 8'hff} : {8'(a % b), 8'(a / b)};
        endcase
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({req0_ready, req1_ready, rsp_valid, rsp_err, rsp_id, rsp_data,
                    alu_begin, alu_op_code, alu_inbus, alu_reset});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push(input bit id, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int dly, input bit hang);
        req_t r;
        r = '{op: op, a: a, b: b, dly: dly, hang: hang};
        if (id) rq1.push_back(r);
        else    rq0.push_back(r);
    endtask

    always @(posedge clk) begin
        #1;
        if (acc0 && rq0.size() > 0) rq0.delete(0);
        if (acc1 && rq1.size() > 0) rq1.delete(0);
        acc0 = 1'b0;
        acc1 = 1'b0;
        req0_valid = rq0.size() > 0;
        req1_valid = rq1.size() > 0;
        req0_op = req0_valid ? rq0[0].op : 2'($urandom);
        req0_a  = req0_valid ? rq0[0].a  : 8'($urandom);
        req0_b  = req0_valid ? rq0[0].b  : 8'($urandom);
        req1_op = req1_valid ? rq1[0].op : 2'($urandom);
        req1_a  = req1_valid ? rq1[0].a  : 8'($urandom);
        req1_b  = req1_valid ? rq1[0].b  : 8'($urandom);
        rsp_ready = (rdy_mode == 1) ? 1'b1 :
                    (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Accept side: predicts the grant and pushes the expected response.
    always @(negedge clk) begin
        if (!reset && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
            bit          gid;
            req_t        r;
            logic [15:0] d;
            int          due;
            gid = (req0_valid && req1_valid) ? !model_last : req1_valid;
            check("grant", {req1_ready, req0_ready}, gid ? 2'b10 : 2'b01);
            model_last = gid;
            r = gid ? rq1[0] : rq0[0];
            cur_dly  = r.dly;
            cur_hang = r.hang;
            d   = r.hang ? 16'h0000 : ref_result(r.op, r.a, r.b);
            due = cyc + (r.hang ? 5 + TMO : 4 + r.dly + int'(r.op[1]));
            exp_q.push_back({32'(due), gid, r.hang, d});
            if (gid) acc1 = 1'b1;
            else     acc0 = 1'b1;
        end
    end

    // ---------------- ALU model ----------------
    int          bcnt = 0;
    int          wcnt = 0;
    logic [1:0]  mop;
    logic [7:0]  ma, mb;
    logic [15:0] mres;

    always @(posedge clk) begin
        #1;
        if (reset || alu_reset) begin
            bcnt = 0;
            alu_end = 1'b0;
            alu_outbus = 8'h00;
        end else begin
            alu_end = 1'b0;
            alu_outbus = 8'($urandom);
            case (bcnt)
                0: if (alu_begin) begin
                    mop = alu_op_code;
                    check("issue_inbus", alu_inbus, 8'h00);
                    bcnt = 1;
                end
                1: begin
                    check("load_a_begin", alu_begin, 1'b1);
                    ma = alu_inbus;
                    bcnt = 2;
                end
                2: begin
                    check("wait_begin", alu_begin, 1'b0);
                    mb = alu_inbus;
                    mres = ref_result(mop, ma, mb);
                    wcnt = 0;
                    bcnt = 3;
                end
                4: begin
                    alu_outbus = mres[15:8];
                    bcnt = 0;
                end
                default: ;
            endcase
            if (bcnt == 3) begin
                check("op_hold", alu_op_code, mop);
                if (!cur_hang && wcnt == cur_dly) begin
                    alu_end = 1'b1;
                    alu_outbus = mres[7:0];
                    bcnt = 4;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    bit          shown = 1'b0;
    bit          drop_chk = 1'b0;
    int          rst_cnt = 0;
    logic [15:0] hd;
    logic        hid, herr;

    always @(negedge clk) begin
        if (reset) begin
            shown = 1'b0;
            drop_chk = 1'b0;
            rst_cnt = 0;
        end else begin
            if (alu_reset) rst_cnt++;
            if (drop_chk) begin
                check("rsp_drop", rsp_valid, 1'b0);
                drop_chk = 1'b0;
            end else if (rsp_valid) begin
                if (!shown) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 1'b0);
                    end else begin
                        logic [49:0] e;
                        e = exp_q.pop_front();
                        check("rsp_id", rsp_id, e[17]);
                        check("rsp_err", rsp_err, e[16]);
                        check("rsp_data", rsp_data, e[15:0]);
                        check("rsp_cycle", cyc, e[49:18]);
                        check("alu_reset_len", rst_cnt, e[16] ? 2 : 0);
                    end
                    rst_cnt = 0;
                    shown = 1'b1;
                    hd = rsp_data; hid = rsp_id; herr = rsp_err;
                end else begin
                    check("rsp_hold", {rsp_id, rsp_err, rsp_data}, {hid, herr, hd});
                end
                if (rsp_ready) begin
                    shown = 1'b0;
                    drop_chk = 1'b1;
                end
            end
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic drain(input int limit);
        int n = 0;
        while ((rq0.size() + rq1.size() + exp_q.size() > 0 || shown) && n < limit) begin
            @(posedge clk);
            n++;
        end
        check("drain", rq0.size() + rq1.size() + exp_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        rq0.delete();
        rq1.delete();
        exp_q.delete();
        model_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_outs", all_outs(), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- main ----------------
    initial begin
        reset = 1'b1;
        rsp_ready = 1'b0;
        alu_end = 1'b0;
        alu_outbus = 8'h00;
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", all_outs(), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        push(0, 2'd0, 8'd56, 8'd89, 2, 1'b0);        // add, req0
        drain(200);
        do_reset();
        push(1, 2'd1, 8'd56, 8'd89, 1, 1'b0);        // sub, req1
        drain(200);
        do_reset();
        push(0, 2'd2, 8'd7, 8'd3, 0, 1'b0);          // mul, two-byte capture
        push(0, 2'd3, 8'd200, 8'd7, 3, 1'b0);        // div
        drain(300);

        do_reset();
        for (int i = 0; i < 4; i++) begin            // ties alternate 0,1,0,1...
            push(0, 2'(i), 8'(10 + i), 8'(3 + i), i, 1'b0);
            push(1, 2'(3 - i), 8'(90 + i), 8'(5 + i), 3 - i, 1'b0);
        end
        drain(600);

        push(0, 2'd0, 8'd1, 8'd2, 0, 1'b1);          // watchdog abort
        drain(200);
        push(1, 2'd2, 8'd200, 8'd100, 3, 1'b0);      // recovers normally
        drain(200);

        rdy_mode = 2;
        for (int i = 0; i < 24; i++) begin
            for (int r = 0; r < 2; r++) begin
                push(1'(r), 2'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, TMO - 1), $urandom_range(0, 7) == 0);
            end
        end
        drain(5000);

        rdy_mode = 1;                                 // reset mid-WAIT
        push(0, 2'd2, 8'd9, 8'd9, TMO - 1, 1'b0);
        repeat (5) @(posedge clk);
        do_reset();
        push(0, 2'd0, 8'd5, 8'd6, 1, 1'b0);
        push(1, 2'd1, 8'd5, 8'd6, 2, 1'b0);
        drain(300);

        rdy_mode = 0;                                 // reset mid-RESPOND
        push(1, 2'd3, 8'd100, 8'd9, 2, 1'b0);
        begin
            int n = 0;
            while (!rsp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("respond_reached", rsp_valid, 1'b1);
        end
        repeat (3) @(posedge clk);
        do_reset();
        rdy_mode = 1;
        push(0, 2'd2, 8'd255, 8'd255, 0, 1'b0);
        push(1, 2'd0, 8'd255, 8'd1, 0, 1'b0);
        drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        n_err++;
        $display("FAIL global_timeout: got cycle %0d, want completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
